// File: rtl/pie_dec.sv
// pie_dec: PIE receive decoder turning the reader envelope into command bits,
// RTcal/TRcal measurements and end-of-command / error strobes.
module pie_dec #(
    parameter int CNT_W     = 10,
    parameter int DELIM_MIN = 16,
    parameter int DELIM_MAX = 32
) (
    input  logic             clk_dpie,
    input  logic             rst_n,
    input  logic             en_rx,
    input  logic             pie_code,
    output logic             rx_bit,
    output logic             rx_bit_vld,
    output logic             preamble,
    output logic [CNT_W-1:0] rtcal,
    output logic [CNT_W-1:0] trcal,
    output logic             cmd_done,
    output logic             rx_err
);
    localparam int W = CNT_W + 2;
    localparam logic [W-1:0] DMIN = W'(DELIM_MIN);
    localparam logic [W-1:0] DMAX = W'(DELIM_MAX);

    typedef enum logic [2:0] {IDLE, DELIM, TARI, RTCAL, CAL_OR_DATA, DATA} state_t;
    state_t state_q, state_d;

    logic s1_q, s2_q, s3_q, fall_pend_q, fall_pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, tari_q, tari_d, pivot_q, pivot_d;
    logic [CNT_W-1:0] rtcal_q, rtcal_d, trcal_q, trcal_d;
    logic bit_q, bit_d, vld_q, vld_d, pre_q, pre_d, done_q, done_d, err_q, err_d;

    logic rise, fall, sat, delim_ok, rt_ok, tmo, is_tr, meas, cal, rt_set;
    logic [CNT_W-1:0] len_c;
    logic [W-1:0] len, tari2, rt_lo, rt_hi;

    assign rise  = s2_q & ~s3_q;
    assign fall  = ~s2_q & s3_q;
    assign sat   = &cnt_q;
    // saturating increment doubles as the measured length of the current interval
    assign len_c = cnt_q + CNT_W'(!sat);
    assign len   = {2'b0, len_c};
    assign tari2 = {1'b0, tari_q, 1'b0};
    assign rt_lo = tari2 + {3'b0, tari_q[CNT_W-1:1]};
    assign rt_hi = tari2 + {2'b0, tari_q};
    assign delim_ok = (len >= DMIN) && (len <= DMAX);
    assign rt_ok    = (len >= rt_lo) && (len <= rt_hi);
    assign tmo      = (len >= {1'b0, rtcal_q, 1'b0}) || sat;
    assign is_tr    = len > {2'b0, rtcal_q};
    assign meas     = state_q inside {DELIM, TARI, RTCAL, CAL_OR_DATA};

    always_ff @(posedge clk_dpie or negedge rst_n) begin
        if (!rst_n) begin
            {s1_q, s2_q, s3_q} <= 3'b111;
            state_q     <= IDLE;
            fall_pend_q <= 1'b0;
            cnt_q       <= '0;
            tari_q      <= '0;
            pivot_q     <= '0;
            rtcal_q     <= '0;
            trcal_q     <= '0;
            {bit_q, vld_q, pre_q, done_q, err_q} <= '0;
        end else begin
            {s1_q, s2_q, s3_q} <= {pie_code, s1_q, s2_q};
            state_q     <= state_d;
            fall_pend_q <= fall_pend_d;
            cnt_q       <= cnt_d;
            tari_q      <= tari_d;
            pivot_q     <= pivot_d;
            rtcal_q     <= rtcal_d;
            trcal_q     <= trcal_d;
            {bit_q, vld_q, pre_q, done_q, err_q} <= {bit_d, vld_d, pre_d, done_d, err_d};
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en_rx) state_d = IDLE;
        else case (state_q)
            IDLE:        if (fall || fall_pend_q) state_d = DELIM;
            DELIM:       if (rise) state_d = delim_ok ? TARI : IDLE; else if (sat) state_d = IDLE;
            TARI:        if (rise) state_d = RTCAL; else if (sat) state_d = IDLE;
            RTCAL:       if (rise) state_d = rt_ok ? CAL_OR_DATA : IDLE; else if (sat) state_d = IDLE;
            CAL_OR_DATA: if (rise) state_d = DATA; else if (sat) state_d = IDLE;
            DATA:        if (!rise && tmo) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_comb begin
        err_d  = en_rx & (rise ? ((state_q == DELIM) & !delim_ok) | ((state_q == RTCAL) & !rt_ok)
                               : meas & sat);
        done_d = en_rx & (state_q == DATA) & !rise & tmo;
        cal    = en_rx & rise & (state_q == CAL_OR_DATA);
        rt_set = en_rx & rise & (state_q == RTCAL) & rt_ok;
        vld_d  = en_rx & rise & ((state_q == DATA) | ((state_q == CAL_OR_DATA) & !is_tr));
        bit_d  = vld_d & (len > {2'b0, pivot_q});
        tari_d  = (en_rx & rise & (state_q == TARI)) ? len_c : tari_q;
        rtcal_d = rt_set ? len_c : rtcal_q;
        pivot_d = rt_set ? len_c >> 1 : pivot_q;
        pre_d   = cal ? is_tr : pre_q;
        trcal_d = cal ? (is_tr ? len_c : '0) : trcal_q;
        // a fall coinciding with cmd_done starts the next delimiter measurement
        cnt_d       = (rise | (fall & ((state_q == IDLE) | done_d))) ? '0 : len_c;
        fall_pend_d = done_d & fall;
    end

    assign rx_bit     = bit_q;
    assign rx_bit_vld = vld_q;
    assign preamble   = pre_q;
    assign rtcal      = rtcal_q;
    assign trcal      = trcal_q;
    assign cmd_done   = done_q;
    assign rx_err     = err_q;
endmodule

// File: tb/tb_pie_dec.sv
// tb_pie_dec: directed PIE frames against hand-computed decode results
// (Tari 20, RTcal 56, TRcal 112, delimiter 24).
module tb_pie_dec;
    localparam int PW = 8;

    logic       clk_dpie = 1'b0, rst_n = 1'b0, en_rx = 1'b1, pie_code = 1'b1;
    logic       rx_bit, rx_bit_vld, preamble, cmd_done, rx_err;
    logic [9:0] rtcal, trcal;

    int n_vec = 0, n_mis = 0, cyc = 0;
    int n_bits = 0, n_done = 0, n_err = 0, t_vld = 0, t_done = 0;
    logic [15:0] bits = '0;

    pie_dec dut (
        .clk_dpie(clk_dpie), .rst_n(rst_n), .en_rx(en_rx), .pie_code(pie_code),
        .rx_bit(rx_bit), .rx_bit_vld(rx_bit_vld), .preamble(preamble),
        .rtcal(rtcal), .trcal(trcal), .cmd_done(cmd_done), .rx_err(rx_err)
    );

    always #5 clk_dpie = ~clk_dpie;
    always @(posedge clk_dpie) cyc <= cyc + 1;

    always @(negedge clk_dpie) begin
        if (rx_bit_vld) begin
            bits = {bits[14:0], rx_bit};
            n_bits++;
            t_vld = cyc;
        end
        if (cmd_done) begin
            n_done++;
            t_done = cyc;
        end
        if (rx_err) n_err++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int k);
        repeat (k) @(posedge clk_dpie);
        #1;
    endtask

    task automatic clr();
        bits = '0; n_bits = 0; n_done = 0; n_err = 0; t_vld = 0; t_done = 0;
    endtask

    // delimiter low for dl cycles, then n symbols measured rise-to-rise, ending high
    task automatic frame(input int dl, input int n, input int s[8]);
        pie_code = 1'b0;
        wait_n(dl);
        for (int i = 0; i < n; i++) begin
            pie_code = 1'b1;
            wait_n(s[i] - PW);
            pie_code = 1'b0;
            wait_n(PW);
        end
        pie_code = 1'b1;
    endtask

    task automatic wait_done(input int lim);
        int k = 0;
        while (n_done == 0 && k < lim) begin
            wait_n(1);
            k++;
        end
        wait_n(4);
    endtask

    initial begin
        #1;
        chk("rst_bit", 32'(rx_bit), 0);
        chk("rst_vld", 32'(rx_bit_vld), 0);
        chk("rst_pre", 32'(preamble), 0);
        chk("rst_rtcal", 32'(rtcal), 0);
        chk("rst_trcal", 32'(trcal), 0);
        chk("rst_done", 32'(cmd_done), 0);
        chk("rst_err", 32'(rx_err), 0);
        wait_n(3);
        rst_n = 1'b1;
        wait_n(5);

        clr();
        frame(24, 7, '{20, 56, 112, 36, 20, 20, 20, 0});
        wait_done(300);
        chk("q_nbits", n_bits, 4);
        chk("q_bits", 32'(bits[3:0]), 4'b1000);
        chk("q_pre", 32'(preamble), 1);
        chk("q_rtcal", 32'(rtcal), 56);
        chk("q_trcal", 32'(trcal), 112);
        chk("q_done", n_done, 1);
        chk("q_err", n_err, 0);
        chk("q_tdone", t_done - t_vld, 112);

        clr();
        frame(24, 4, '{20, 56, 20, 36, 0, 0, 0, 0});
        wait_done(300);
        chk("fs_nbits", n_bits, 2);
        chk("fs_bits", 32'(bits[1:0]), 2'b01);
        chk("fs_pre", 32'(preamble), 0);
        chk("fs_trcal", 32'(trcal), 0);
        chk("fs_done", n_done, 1);

        clr();
        frame(10, 0, '{0, 0, 0, 0, 0, 0, 0, 0});
        wait_n(30);
        chk("sd_err", n_err, 1);
        chk("sd_nbits", n_bits, 0);
        chk("sd_done", n_done, 0);
        clr();
        frame(24, 7, '{20, 56, 112, 36, 20, 20, 20, 0});
        wait_done(300);
        chk("sd2_bits", 32'(bits[3:0]), 4'b1000);
        chk("sd2_nbits", n_bits, 4);
        chk("sd2_err", n_err, 0);

        clr();
        frame(24, 2, '{20, 70, 0, 0, 0, 0, 0, 0});
        wait_n(20);
        chk("rt70_err", n_err, 1);
        chk("rt70_nbits", n_bits, 0);
        clr();
        frame(24, 3, '{20, 50, 20, 0, 0, 0, 0, 0});
        wait_done(300);
        chk("rt50_rtcal", 32'(rtcal), 50);
        chk("rt50_bits", {16'(n_bits), 16'(bits[0])}, {16'd1, 16'd0});
        chk("rt50_err", n_err, 0);
        clr();
        frame(24, 3, '{20, 60, 36, 0, 0, 0, 0, 0});
        wait_done(300);
        chk("rt60_rtcal", 32'(rtcal), 60);
        chk("rt60_bits", {16'(n_bits), 16'(bits[0])}, {16'd1, 16'd1});
        chk("rt60_err", n_err, 0);

        clr();
        frame(24, 5, '{20, 56, 20, 28, 29, 0, 0, 0});
        wait_done(300);
        chk("pv_nbits", n_bits, 3);
        chk("pv_bits", 32'(bits[2:0]), 3'b001);
        chk("pv_done", n_done, 1);

        clr();
        frame(24, 4, '{20, 56, 112, 36, 0, 0, 0, 0});
        wait_n(10);
        chk("rs_pre_before", 32'(preamble), 1);
        rst_n = 1'b0;
        #1;
        chk("rs_pre", 32'(preamble), 0);
        chk("rs_rtcal", 32'(rtcal), 0);
        chk("rs_trcal", 32'(trcal), 0);
        chk("rs_strobes", {29'd0, rx_bit_vld, cmd_done, rx_err}, 0);
        wait_n(3);
        rst_n = 1'b1;
        clr();
        wait_n(200);
        chk("rs_done", n_done, 0);
        chk("rs_err", n_err, 0);

        clr();
        frame(24, 3, '{20, 56, 20, 0, 0, 0, 0, 0});
        wait_n(10);
        en_rx = 1'b0;
        wait_n(200);
        chk("en_nbits", n_bits, 1);
        chk("en_done", n_done, 0);
        chk("en_err", n_err, 0);
        en_rx = 1'b1;
        wait_n(5);
        clr();
        frame(24, 7, '{20, 56, 112, 36, 20, 20, 20, 0});
        wait_done(300);
        chk("en2_bits", 32'(bits[3:0]), 4'b1000);
        chk("en2_done", n_done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
